hc_dot_engine: RTL

HC_DOT_ENGINE -- requirements
Module: hc_dot_engine

---
 rtl/hc_pkg.sv | 37 +++
 rtl/hc_sat_q17_14.sv | 24 ++
 rtl/hc_dot_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hc_pkg.sv
// Shared constants for the Q17.14 dot-product engine: feature count, format,
// weight/bias table and the controller state encoding.
package hc_pkg;

   localparam int N_FEAT       = 6;
   localparam int HC_FRAC_BITS = 14;
   localparam int ACC_W        = 52;
   localparam int IDX_W        = 3;

   localparam logic signed [31:0] BIAS = 32'sh0000_0000;
   localparam logic signed [31:0] W0   = 32'sh0000_4000;
   localparam logic signed [31:0] W1   = 32'sh0000_4000;
   localparam logic signed [31:0] W2   = 32'sh0000_4000;
   localparam logic signed [31:0] W3   = 32'sh0000_4000;
   localparam logic signed [31:0] W4   = 32'sh0000_4000;
   localparam logic signed [31:0] W5   = 32'sh0000_4000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } hc_state_e;

   // Weight lookup by feature index; out-of-range indices contribute nothing.
   function automatic logic signed [31:0] hc_weight(input logic [IDX_W-1:0] i);
      case (i)
         3'd0:    hc_weight = W0;
         3'd1:    hc_weight = W1;
         3'd2:    hc_weight = W2;
         3'd3:    hc_weight = W3;
         3'd4:    hc_weight = W4;
         3'd5:    hc_weight = W5;
         default: hc_weight = 32'sh0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/hc_sat_q17_14.sv
// Clips the wide accumulator to the signed 32-bit Q17.14 range and flags
// whether clipping happened.
module hc_sat_q17_14
   import hc_pkg::*;
(
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [31:0]      q_o,
   output logic                    sat_o
);

   logic [ACC_W-32:0] top_bits;

   // The value fits in 32 bits exactly when bits [ACC_W-1:31] are all equal.
   always_comb begin
      top_bits = acc_i[ACC_W-1:31];
      sat_o    = 1'b0;
      q_o      = acc_i[31:0];
      if (!((&top_bits) || !(|top_bits))) begin
         sat_o = 1'b1;
         q_o   = acc_i[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      end
   end

endmodule

// File: rtl/hc_dot_engine.sv
// Six-feature Q17.14 weighted-sum classifier using one shared multiplier,
// one product per cycle, with a valid/ready handshake on each side.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1; waits for a vector, captures it and loads BIAS
//   MAC   | one multiply-accumulate per cycle, idx 0..5
//   DONE  | out_valid=1; result held until out_ready
module hc_dot_engine
   import hc_pkg::*;
#(
   parameter int                 FRAC_BITS = HC_FRAC_BITS,
   parameter logic signed [31:0] THRESH    = 32'sd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] in0,
   input  logic signed [31:0] in1,
   input  logic signed [31:0] in2,
   input  logic signed [31:0] in3,
   input  logic signed [31:0] in4,
   input  logic signed [31:0] in5,
   input  logic               in_valid,
   output logic               in_ready,
   output logic signed [31:0] score,
   output logic               class_out,
   output logic               sat,
   output logic               out_valid,
   input  logic               out_ready
);

   hc_state_e state_q, state_d;

   logic signed [31:0]      x_q [N_FEAT];
   logic signed [31:0]      x_d [N_FEAT];
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [31:0]      score_q, score_d;
   logic                    class_q, class_d;
   logic                    sat_q, sat_d;

   logic signed [31:0]      x_sel;
   logic signed [31:0]      w_sel;
   logic signed [63:0]      prod;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] mac_sum;
   logic signed [31:0]      clip_val;
   logic                    clip_sat;

   // Shared datapath: select feature/weight by idx, scale, accumulate.
   always_comb begin
      x_sel = 32'sh0000_0000;
      for (int i = 0; i < N_FEAT; i++) begin
         if (idx_q == IDX_W'(i)) x_sel = x_q[i];
      end
      w_sel   = hc_weight(idx_q);
      prod    = x_sel * w_sel;
      term    = ACC_W'(prod >>> FRAC_BITS);
      mac_sum = acc_q + term;
   end

   hc_sat_q17_14 u_sat (
      .acc_i (mac_sum),
      .q_o   (clip_val),
      .sat_o (clip_sat)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      score_d = score_q;
      class_d = class_q;
      sat_d   = sat_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d[0]  = in0;
               x_d[1]  = in1;
               x_d[2]  = in2;
               x_d[3]  = in3;
               x_d[4]  = in4;
               x_d[5]  = in5;
               acc_d   = {{(ACC_W-32){BIAS[31]}}, BIAS};
               idx_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = mac_sum;
            idx_d = idx_q + 1'b1;
            // Last product: register the clipped result as DONE is entered.
            if (idx_q == IDX_W'(N_FEAT - 1)) begin
               idx_d   = '0;
               score_d = clip_val;
               sat_d   = clip_sat;
               class_d = (clip_val > THRESH);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < N_FEAT; i++) x_q[i] <= 32'sh0000_0000;
         idx_q   <= '0;
         acc_q   <= '0;
         score_q <= 32'sh0000_0000;
         class_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < N_FEAT; i++) x_q[i] <= x_d[i];
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         score_q <= score_d;
         class_q <= class_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign score     = score_q;
   assign class_out = class_q;
   assign sat       = sat_q;

endmodule
